// File: rtl/config_field_controller.sv
// -----------------------------------------------------------------------------
// config_field_controller
//
// Sequencer for the time-setting path of the clock/date/timer design. While
// configuration mode is active it selects which BCD field counter may count,
// issues single-cycle up/down count strobes with press-and-hold auto-repeat,
// and produces a blink phase for the display of the selected field.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   reset        in   asynchronous, active-low reset
//   config_mode  in   level, high while the user edits time/date/timer
//   btn_left     in   debounced level, select previous field
//   btn_right    in   debounced level, select next field
//   btn_up       in   debounced level, increment selected field
//   btn_down     in   debounced level, decrement selected field
//   en_count     out  selected field code 1..NUM_FIELDS, 0 = none
//   enUP         out  single-cycle increment strobe
//   enDOWN       out  single-cycle decrement strobe
//   blink        out  blink phase for the selected field display
// -----------------------------------------------------------------------------
module config_field_controller #(
    parameter int NUM_FIELDS    = 9,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 25_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       config_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       blink
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);

    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [BLK_W-1:0] BLK_LAST        = BLK_W'(BLINK_HALF - 1);
    localparam logic [3:0]       FIELD_LAST      = 4'(NUM_FIELDS);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SELECT     = 2'd1,
        ST_HOLD_DELAY = 2'd2,
        ST_REPEAT     = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_en_count;
    logic               r_en_up;
    logic               r_en_down;
    logic               r_blink;
    logic [BLK_W-1:0]   r_blink_cnt;
    logic [RPT_W-1:0]   r_rpt_cnt;
    logic               r_dir_up;
    logic               r_left_d;
    logic               r_right_d;
    logic               r_up_d;
    logic               r_down_d;

    state_t             w_state_nxt;
    logic [3:0]         w_en_count_nxt;
    logic               w_en_up_nxt;
    logic               w_en_down_nxt;
    logic               w_blink_nxt;
    logic [BLK_W-1:0]   w_blink_cnt_nxt;
    logic [RPT_W-1:0]   w_rpt_cnt_nxt;
    logic               w_dir_up_nxt;
    logic               w_field_change;

    logic               w_left_edge;
    logic               w_right_edge;
    logic               w_up_edge;
    logic               w_down_edge;
    logic               w_held;

    assign w_left_edge  = btn_left  & ~r_left_d;
    assign w_right_edge = btn_right & ~r_right_d;
    assign w_up_edge    = btn_up    & ~r_up_d;
    assign w_down_edge  = btn_down  & ~r_down_d;
    // Only the button that started the hold keeps the repeat alive.
    assign w_held       = r_dir_up ? btn_up : btn_down;

    // Previous-cycle button levels; reset high so a button held through reset gives no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left_d  <= 1'b1;
            r_right_d <= 1'b1;
            r_up_d    <= 1'b1;
            r_down_d  <= 1'b1;
        end else begin
            r_left_d  <= btn_left;
            r_right_d <= btn_right;
            r_up_d    <= btn_up;
            r_down_d  <= btn_down;
        end
    end

    // Next-state, field selection, strobe, repeat and blink logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_en_count_nxt  = r_en_count;
        w_en_up_nxt     = 1'b0;
        w_en_down_nxt   = 1'b0;
        w_dir_up_nxt    = r_dir_up;
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_blink_nxt     = r_blink;
        w_blink_cnt_nxt = r_blink_cnt;
        w_field_change  = 1'b0;

        if (!config_mode) begin
            // Leaving config mode overrides every other event.
            w_state_nxt     = ST_IDLE;
            w_en_count_nxt  = 4'd0;
            w_dir_up_nxt    = 1'b0;
            w_rpt_cnt_nxt   = '0;
            w_blink_nxt     = 1'b0;
            w_blink_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt    = ST_SELECT;
                    w_en_count_nxt = 4'd1;
                    w_field_change = 1'b1;
                end
                ST_SELECT: begin
                    if (w_up_edge && !w_down_edge) begin
                        w_en_up_nxt   = 1'b1;
                        w_dir_up_nxt  = 1'b1;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_HOLD_DELAY;
                    end else if (w_down_edge && !w_up_edge) begin
                        w_en_down_nxt = 1'b1;
                        w_dir_up_nxt  = 1'b0;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_HOLD_DELAY;
                    end else if (w_up_edge || w_down_edge) begin
                        // Both count edges at once: ignored, and any
                        // left/right edge in this cycle is dropped too.
                        w_state_nxt = ST_SELECT;
                    end else if (w_right_edge && !w_left_edge) begin
                        w_en_count_nxt = (r_en_count >= FIELD_LAST) ? 4'd1 : (r_en_count + 4'd1);
                        w_field_change = 1'b1;
                    end else if (w_left_edge && !w_right_edge) begin
                        w_en_count_nxt = (r_en_count <= 4'd1) ? FIELD_LAST : (r_en_count - 4'd1);
                        w_field_change = 1'b1;
                    end else begin
                        w_state_nxt = ST_SELECT;
                    end
                end
                ST_HOLD_DELAY: begin
                    if (!w_held) begin
                        w_state_nxt   = ST_SELECT;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == RPT_DELAY_LAST) begin
                        w_en_up_nxt   = r_dir_up;
                        w_en_down_nxt = ~r_dir_up;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = ST_REPEAT;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!w_held) begin
                        w_state_nxt   = ST_SELECT;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == RPT_PERIOD_LAST) begin
                        w_en_up_nxt   = r_dir_up;
                        w_en_down_nxt = ~r_dir_up;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_en_count_nxt = 4'd0;
                    w_rpt_cnt_nxt  = '0;
                end
            endcase

            // A newly selected field always starts visible with a fresh half-period.
            if (w_field_change) begin
                w_blink_nxt     = 1'b1;
                w_blink_cnt_nxt = '0;
            end else if (r_blink_cnt == BLK_LAST) begin
                w_blink_nxt     = ~r_blink;
                w_blink_cnt_nxt = '0;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BLK_W'(1);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_en_count  <= 4'd0;
            r_en_up     <= 1'b0;
            r_en_down   <= 1'b0;
            r_dir_up    <= 1'b0;
            r_rpt_cnt   <= '0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_en_count  <= w_en_count_nxt;
            r_en_up     <= w_en_up_nxt;
            r_en_down   <= w_en_down_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_blink     <= w_blink_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
        end
    end

    assign en_count = r_en_count;
    assign enUP     = r_en_up;
    assign enDOWN   = r_en_down;
    assign blink    = r_blink;

endmodule

// File: tb/tb_config_field_controller.sv
// -----------------------------------------------------------------------------
// tb_config_field_controller
//
// Directed self-checking bench for config_field_controller with
// NUM_FIELDS=9, REPEAT_DELAY=8, REPEAT_PERIOD=4, BLINK_HALF=5.
// Cycle k is the interval after the k-th rising edge counted from the point
// an input is applied; inputs change and outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_config_field_controller;

    logic       clk;
    logic       reset;
    logic       config_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       blink;

    int errors = 0;
    int checks = 0;

    config_field_controller #(
        .NUM_FIELDS    (9),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .BLINK_HALF    (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .config_mode (config_mode),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .en_count    (en_count),
        .enUP        (enUP),
        .enDOWN      (enDOWN),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_b;

        reset       = 1'b0;
        config_mode = 1'b0;
        btn_left    = 1'b0;
        btn_right   = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_en_count", 32'(en_count), 32'd0);
        chk("rst_enUP",     32'(enUP),     32'd0);
        chk("rst_enDOWN",   32'(enDOWN),   32'd0);
        chk("rst_blink",    32'(blink),    32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("idle_en_count", 32'(en_count), 32'd0);
        chk("idle_blink",    32'(blink),    32'd0);

        // Enter config in cycle 0: field 1, blink 1 at cycle 1, toggles at 6, 11, 16
        config_mode = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_b = ((((c - 1) / 5) % 2) == 0) ? 1'b1 : 1'b0;
            chk($sformatf("blink_c%0d", c), 32'(blink), 32'(exp_b));
            chk($sformatf("nostrobe_c%0d", c), 32'({enUP, enDOWN}), 32'd0);
            if (c == 1) chk("enter_en_count", 32'(en_count), 32'd1);
        end

        // Nine right pulses walk 2..9 then wrap to 1
        for (int i = 1; i <= 9; i++) begin
            btn_right = 1'b1;
            tick();
            chk($sformatf("right_%0d", i), 32'(en_count), (i == 9) ? 32'd1 : 32'(i + 1));
            chk($sformatf("right_blink_%0d", i), 32'(blink), 32'd1);
            btn_right = 1'b0;
            tick();
        end

        // Left from field 1 wraps to 9
        btn_left = 1'b1;
        tick();
        chk("left_wrap", 32'(en_count), 32'd9);
        btn_left = 1'b0;
        tick();

        // Simultaneous left and right: unchanged
        btn_left  = 1'b1;
        btn_right = 1'b1;
        tick();
        chk("lr_both", 32'(en_count), 32'd9);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick();
        chk("lr_both_after", 32'(en_count), 32'd9);

        // btn_up high cycles 0..18: enUP at 1, 9, 13, 17
        btn_up = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("up_hold_enUP_c%0d", c), 32'(enUP),
                (c == 1 || c == 9 || c == 13 || c == 17) ? 32'd1 : 32'd0);
            chk($sformatf("up_hold_enDOWN_c%0d", c), 32'(enDOWN), 32'd0);
            chk($sformatf("up_hold_field_c%0d", c), 32'(en_count), 32'd9);
            if (c == 19) btn_up = 1'b0;
        end
        // Back in SELECT at cycle 20: a right edge now moves the field
        btn_right = 1'b1;
        tick();
        chk("select_after_release", 32'(en_count), 32'd1);
        btn_right = 1'b0;
        tick();

        // One-cycle btn_down tap
        btn_down = 1'b1;
        tick();
        chk("tap_enDOWN", 32'(enDOWN), 32'd1);
        chk("tap_enUP",   32'(enUP),   32'd0);
        btn_down = 1'b0;
        tick();
        chk("tap_enDOWN_off", 32'(enDOWN), 32'd0);
        tick();
        chk("tap_enDOWN_off2", 32'(enDOWN), 32'd0);

        // Down hold: up and right presses are ignored; repeat down at cycle 9
        btn_down = 1'b1;
        tick();
        chk("dhold_first", 32'(enDOWN), 32'd1);
        btn_up    = 1'b1;
        btn_right = 1'b1;
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk($sformatf("dhold_enUP_c%0d", c), 32'(enUP), 32'd0);
            chk($sformatf("dhold_enDOWN_c%0d", c), 32'(enDOWN), (c == 9) ? 32'd1 : 32'd0);
            chk($sformatf("dhold_field_c%0d", c), 32'(en_count), 32'd1);
            if (c == 2) btn_right = 1'b0;
        end
        btn_down = 1'b0;
        btn_up   = 1'b0;
        tick();
        chk("dhold_release", 32'({enUP, enDOWN}), 32'd0);
        tick();

        // Up and down edges together in SELECT: no strobe
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("ud_both_c%0d", c), 32'({enUP, enDOWN}), 32'd0);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick();

        // Drop config_mode during REPEAT
        btn_up = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1 || c == 9) chk($sformatf("drop_pre_enUP_c%0d", c), 32'(enUP), 32'd1);
            if (c == 10) config_mode = 1'b0;
        end
        for (int c = 11; c <= 16; c++) begin
            tick();
            chk($sformatf("drop_field_c%0d", c), 32'(en_count), 32'd0);
            chk($sformatf("drop_blink_c%0d", c), 32'(blink), 32'd0);
            chk($sformatf("drop_strobe_c%0d", c), 32'({enUP, enDOWN}), 32'd0);
        end

        // Re-enter config with btn_up still held: no edge, no strobe
        config_mode = 1'b1;
        tick();
        chk("reenter_field", 32'(en_count), 32'd1);
        chk("reenter_strobe", 32'({enUP, enDOWN}), 32'd0);
        tick();
        chk("reenter_strobe2", 32'({enUP, enDOWN}), 32'd0);

        // Reset mid-HOLD_DELAY clears outputs asynchronously
        btn_up = 1'b0;
        tick();
        btn_up = 1'b1;
        tick();
        chk("pre_reset_enUP", 32'(enUP), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_enUP",  32'(enUP),     32'd0);
        chk("async_rst_field", 32'(en_count), 32'd0);
        chk("async_rst_blink", 32'(blink),    32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst_field", 32'(en_count), 32'd1);
        chk("post_rst_enUP",  32'(enUP),     32'd0);
        // btn_up was held across reset release: never a strobe
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("held_rst_c%0d", c), 32'({enUP, enDOWN}), 32'd0);
        end
        btn_up = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
